prob_counter_array: RTL and testbench

- Per-flow counter table with probabilistic (approximate) and exact increment modes.
- Holds 2^C_ID_WIDTH counters internally.
- Runs a 2-stage read-modify-write pipeline with same-ID forwarding, saturating arithmetic and a shared host read/clear port.
- Sits after flow classification in the measurement path and replaces external counter storage plus the single-shot update generator.

---
 rtl/prob_counter_array.sv | 237 +++++++++++++++++++++++
 tb/tb_prob_counter_array.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prob_counter_array.sv
// prob_counter_array
// Per-flow counter table with exact and probabilistic increment modes.
// Two-stage read-modify-write pipeline: the first edge captures the op and
// the old counter value (forwarded from the write in flight when the IDs
// match), the second edge commits the new value and drives the result
// strobes. A shared host port reads or read-and-clears a counter and takes
// priority over update requests.

module prob_counter_array #(
    parameter int unsigned C_ID_WIDTH      = 8,
    parameter int unsigned C_COUNTER_WIDTH = 20,
    parameter int unsigned C_PD_WIDTH      = 32,
    parameter logic [31:0] C_LFSR_SEED     = 32'hCAF0AE25
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [C_ID_WIDTH-1:0]      in_id,
    input  logic                       in_mode,
    input  logic [C_PD_WIDTH-1:0]      in_pd_value,
    input  logic                       host_req,
    input  logic [C_ID_WIDTH-1:0]      host_id,
    input  logic                       host_clear,
    output logic                       out_valid,
    output logic [C_ID_WIDTH-1:0]      out_id,
    output logic [C_COUNTER_WIDTH-1:0] out_counter,
    output logic                       out_incremented,
    output logic                       out_saturated,
    output logic                       host_valid,
    output logic [C_COUNTER_WIDTH-1:0] host_data
);

    localparam int                         DEPTH     = 1 << C_ID_WIDTH;
    // Galois feedback taps: bits 4, 9, 10, 11, 14 and 16..25.
    localparam logic [31:0]                LFSR_TAPS = 32'h03FF_4E10;
    localparam logic [C_COUNTER_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        OP_UPDATE = 2'd0,
        OP_READ   = 2'd1,
        OP_CLEAR  = 2'd2
    } op_e;

    // Random source
    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // Counter storage
    logic [C_COUNTER_WIDTH-1:0] mem_q [DEPTH];

    // Stage-1 (accepted op) registers
    logic                       vld_p1_q;
    logic                       vld_p1_d;
    op_e                        op_p1_q;
    op_e                        op_p1_d;
    logic [C_ID_WIDTH-1:0]      id_p1_q;
    logic [C_ID_WIDTH-1:0]      id_p1_d;
    logic                       mode_p1_q;
    logic                       mode_p1_d;
    logic [C_PD_WIDTH-1:0]      pd_p1_q;
    logic [C_PD_WIDTH-1:0]      pd_p1_d;
    logic [C_PD_WIDTH-1:0]      rnd_p1_q;
    logic [C_PD_WIDTH-1:0]      rnd_p1_d;
    logic [C_COUNTER_WIDTH-1:0] old_p1_q;
    logic [C_COUNTER_WIDTH-1:0] old_p1_d;

    // Stage-2 combinational results
    logic                       inc_p2;
    logic                       sat_p2;
    logic [C_COUNTER_WIDTH-1:0] new_p2;
    logic                       wr_en_p2;
    logic [C_COUNTER_WIDTH-1:0] wr_data_p2;
    logic                       fwd_hit;

    // Registered outputs
    logic                       out_valid_q;
    logic                       out_valid_d;
    logic [C_ID_WIDTH-1:0]      out_id_q;
    logic [C_ID_WIDTH-1:0]      out_id_d;
    logic [C_COUNTER_WIDTH-1:0] out_counter_q;
    logic [C_COUNTER_WIDTH-1:0] out_counter_d;
    logic                       out_incremented_q;
    logic                       out_incremented_d;
    logic                       out_saturated_q;
    logic                       out_saturated_d;
    logic                       host_valid_q;
    logic                       host_valid_d;
    logic [C_COUNTER_WIDTH-1:0] host_data_q;
    logic [C_COUNTER_WIDTH-1:0] host_data_d;

    // Host access stalls the update requester for this cycle.
    assign in_ready = ~host_req;

    // Galois LFSR next state: shift left, wrap bit 31 into bit 0 and the taps.
    always_comb begin
        lfsr_d = {lfsr_q[30:0], lfsr_q[31]} ^ (lfsr_q[31] ? LFSR_TAPS : 32'h0);
    end

    // LFSR free-runs every cycle once out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= C_LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Stage 2: compute the new counter value and the write for the op in stage 1.
    always_comb begin
        inc_p2     = 1'b0;
        sat_p2     = 1'b0;
        new_p2     = old_p1_q;
        wr_en_p2   = 1'b0;
        wr_data_p2 = '0;
        if (vld_p1_q) begin
            case (op_p1_q)
                OP_UPDATE: begin
                    inc_p2 = mode_p1_q | (rnd_p1_q <= pd_p1_q);
                    if (inc_p2 && (old_p1_q == CNT_MAX)) begin
                        sat_p2 = 1'b1;
                        new_p2 = old_p1_q;
                    end else begin
                        new_p2 = old_p1_q + {{(C_COUNTER_WIDTH-1){1'b0}}, inc_p2};
                    end
                    wr_en_p2   = 1'b1;
                    wr_data_p2 = new_p2;
                end
                OP_CLEAR: begin
                    wr_en_p2   = 1'b1;
                    wr_data_p2 = '0;
                end
                default: begin
                    wr_en_p2 = 1'b0;
                end
            endcase
        end
    end

    // Stage 1: select the incoming op (host first) and fetch its old value,
    // taking the value stage 2 is writing on this same edge when IDs match.
    always_comb begin
        vld_p1_d  = host_req | in_valid;
        op_p1_d   = OP_UPDATE;
        id_p1_d   = in_id;
        if (host_req) begin
            op_p1_d = host_clear ? OP_CLEAR : OP_READ;
            id_p1_d = host_id;
        end
        mode_p1_d = in_mode;
        pd_p1_d   = in_pd_value;
        rnd_p1_d  = lfsr_q[C_PD_WIDTH-1:0];
        fwd_hit   = wr_en_p2 && (id_p1_q == id_p1_d);
        old_p1_d  = fwd_hit ? wr_data_p2 : mem_q[id_p1_d];
    end

    // Stage-1 control: the valid is cleared by reset so in-flight ops vanish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1_q <= 1'b0;
            op_p1_q  <= OP_UPDATE;
        end else begin
            vld_p1_q <= vld_p1_d;
            op_p1_q  <= op_p1_d;
        end
    end

    // Stage-1 data: qualified by the valid, so no reset is needed.
    always_ff @(posedge clk) begin
        id_p1_q   <= id_p1_d;
        mode_p1_q <= mode_p1_d;
        pd_p1_q   <= pd_p1_d;
        rnd_p1_q  <= rnd_p1_d;
        old_p1_q  <= old_p1_d;
    end

    // Counter table: cleared on reset, written by stage 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_p2) begin
            mem_q[id_p1_q] <= wr_data_p2;
        end
    end

    // Result strobes and payloads for the op leaving stage 2.
    always_comb begin
        out_valid_d       = vld_p1_q && (op_p1_q == OP_UPDATE);
        out_id_d          = out_id_q;
        out_counter_d     = out_counter_q;
        out_incremented_d = 1'b0;
        out_saturated_d   = 1'b0;
        host_valid_d      = vld_p1_q && (op_p1_q != OP_UPDATE);
        host_data_d       = host_data_q;
        if (out_valid_d) begin
            out_id_d          = id_p1_q;
            out_counter_d     = new_p2;
            out_incremented_d = inc_p2 & ~sat_p2;
            out_saturated_d   = sat_p2;
        end
        if (host_valid_d) begin
            host_data_d = old_p1_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q       <= 1'b0;
            out_id_q          <= '0;
            out_counter_q     <= '0;
            out_incremented_q <= 1'b0;
            out_saturated_q   <= 1'b0;
            host_valid_q      <= 1'b0;
            host_data_q       <= '0;
        end else begin
            out_valid_q       <= out_valid_d;
            out_id_q          <= out_id_d;
            out_counter_q     <= out_counter_d;
            out_incremented_q <= out_incremented_d;
            out_saturated_q   <= out_saturated_d;
            host_valid_q      <= host_valid_d;
            host_data_q       <= host_data_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_id          = out_id_q;
    assign out_counter     = out_counter_q;
    assign out_incremented = out_incremented_q;
    assign out_saturated   = out_saturated_q;
    assign host_valid      = host_valid_q;
    assign host_data       = host_data_q;

endmodule

// File: tb/tb_prob_counter_array.sv
// Bench for prob_counter_array: two instances (20-bit and 4-bit counters)
// share one stimulus; a transaction-level model predicts every strobe.

module tb_prob_counter_array;

    localparam int          IDW   = 8;
    localparam int          PDW   = 32;
    localparam logic [31:0] SEED  = 32'hCAF0AE25;
    localparam int          MAX_A = (1 << 20) - 1;
    localparam int          MAX_B = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_mode = 1'b0;
    logic [IDW-1:0] in_id = '0;
    logic [PDW-1:0] in_pd_value = '0;
    logic host_req = 1'b0;
    logic [IDW-1:0] host_id = '0;
    logic host_clear = 1'b0;

    logic a_in_ready, a_out_valid, a_out_incremented, a_out_saturated, a_host_valid;
    logic [IDW-1:0] a_out_id;
    logic [19:0] a_out_counter, a_host_data;
    logic b_in_ready, b_out_valid, b_out_incremented, b_out_saturated, b_host_valid;
    logic [IDW-1:0] b_out_id;
    logic [3:0] b_out_counter, b_host_data;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prob_counter_array #(.C_ID_WIDTH(IDW), .C_COUNTER_WIDTH(20), .C_PD_WIDTH(PDW), .C_LFSR_SEED(SEED)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_id(in_id),
        .in_mode(in_mode), .in_pd_value(in_pd_value), .host_req(host_req), .host_id(host_id),
        .host_clear(host_clear), .out_valid(a_out_valid), .out_id(a_out_id),
        .out_counter(a_out_counter), .out_incremented(a_out_incremented),
        .out_saturated(a_out_saturated), .host_valid(a_host_valid), .host_data(a_host_data));

    prob_counter_array #(.C_ID_WIDTH(IDW), .C_COUNTER_WIDTH(4), .C_PD_WIDTH(PDW), .C_LFSR_SEED(SEED)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_id(in_id),
        .in_mode(in_mode), .in_pd_value(in_pd_value), .host_req(host_req), .host_id(host_id),
        .host_clear(host_clear), .out_valid(b_out_valid), .out_id(b_out_id),
        .out_counter(b_out_counter), .out_incremented(b_out_incremented),
        .out_saturated(b_out_saturated), .host_valid(b_host_valid), .host_data(b_host_data));

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit uv; int id;
        int ca; bit ia; bit sa;
        int cb; bit ib; bit sb;
        bit hv; int ha; int hb;
    } res_t;

    int cnt_a [256];
    int cnt_b [256];
    logic [31:0] mlf = SEED;
    res_t pend = '{default: 0};
    res_t vis = '{default: 0};
    bit m_inc;
    int taps [15] = '{4, 9, 10, 11, 14, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25};

    function automatic logic [31:0] lfsr_next(input logic [31:0] r, input int tp [15]);
        logic [31:0] n;
        for (int i = 1; i < 32; i++) n[i] = r[i-1];
        n[0] = r[31];
        for (int k = 0; k < 15; k++) n[tp[k]] = r[tp[k]-1] ^ r[31];
        return n;
    endfunction

    // Counters change atomically when an op is accepted; its strobe becomes
    // visible one edge later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) begin cnt_a[i] = 0; cnt_b[i] = 0; end
            mlf = SEED;
            pend = '{default: 0};
            vis = '{default: 0};
        end else begin
            vis = pend;
            pend = '{default: 0};
            if (host_req) begin
                pend.hv = 1; pend.ha = cnt_a[host_id]; pend.hb = cnt_b[host_id];
                if (host_clear) begin cnt_a[host_id] = 0; cnt_b[host_id] = 0; end
            end else if (in_valid) begin
                m_inc = in_mode || (mlf[PDW-1:0] <= in_pd_value);
                pend.uv = 1; pend.id = int'(in_id);
                if (m_inc && cnt_a[in_id] == MAX_A) pend.sa = 1;
                else begin cnt_a[in_id] += int'(m_inc); pend.ia = m_inc; end
                if (m_inc && cnt_b[in_id] == MAX_B) pend.sb = 1;
                else begin cnt_b[in_id] += int'(m_inc); pend.ib = m_inc; end
                pend.ca = cnt_a[in_id]; pend.cb = cnt_b[in_id];
            end
            mlf = lfsr_next(mlf, taps);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("a_in_ready", a_in_ready, !host_req);
        chk("b_in_ready", b_in_ready, !host_req);
        chk("a_out_valid", a_out_valid, vis.uv);
        chk("b_out_valid", b_out_valid, vis.uv);
        chk("both_strobes", a_out_valid && a_host_valid, 0);
        if (vis.uv) begin
            chk("a_out_id", a_out_id, vis.id);
            chk("a_out_counter", a_out_counter, vis.ca);
            chk("a_out_incremented", a_out_incremented, vis.ia);
            chk("a_out_saturated", a_out_saturated, vis.sa);
            chk("b_out_id", b_out_id, vis.id);
            chk("b_out_counter", b_out_counter, vis.cb);
            chk("b_out_incremented", b_out_incremented, vis.ib);
            chk("b_out_saturated", b_out_saturated, vis.sb);
        end
        chk("a_host_valid", a_host_valid, vis.hv);
        chk("b_host_valid", b_host_valid, vis.hv);
        if (vis.hv) begin
            chk("a_host_data", a_host_data, vis.ha);
            chk("b_host_data", b_host_data, vis.hb);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input int id, input bit mode, input logic [31:0] pd);
        in_valid = 1'b1; in_id = IDW'(id); in_mode = mode; in_pd_value = pd;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic host_read(input int id, input bit clr, output longint va, output longint vb);
        bit seen;
        in_valid = 1'b0;
        host_req = 1'b1; host_id = IDW'(id); host_clear = clr;
        tick();
        host_req = 1'b0; host_clear = 1'b0;
        seen = 0; va = -1; vb = -1;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            if (a_host_valid) begin seen = 1; va = a_host_data; vb = b_host_data; end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL host_read_timeout id=%0d actual=no_strobe required=strobe", id);
        end
    endtask

    longint va, vb, mexp;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_host_valid", a_host_valid, 0);
        chk("rst_out_counter", a_out_counter, 0);
        chk("rst_out_id", a_out_id, 0);
        chk("rst_host_data", a_host_data, 0);
        chk("rst_out_incremented", a_out_incremented, 0);
        chk("rst_out_saturated", b_out_saturated, 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Exact mode, id 5, three back-to-back
        upd(5, 1, 0);
        upd(5, 1, 0);
        chk("exact_r1", a_out_counter, 1);
        upd(5, 1, 0);
        chk("exact_r2", a_out_counter, 2);
        idle();
        chk("exact_r3", a_out_counter, 3);
        chk("exact_r3_inc", a_out_incremented, 1);
        host_read(5, 0, va, vb);
        chk("exact_read5", va, 3);

        // Forwarding 7,7,9,7
        upd(7, 1, 0); upd(7, 1, 0); upd(9, 1, 0); upd(7, 1, 0);
        idle();
        chk("fwd_last7", a_out_counter, 3);
        host_read(7, 0, va, vb);
        chk("fwd_read7", va, 3);
        host_read(9, 0, va, vb);
        chk("fwd_read9", va, 1);

        // Saturation on the 4-bit instance
        for (int i = 0; i < 17; i++) upd(2, 1, 0);
        idle();
        chk("sat_b_counter", b_out_counter, 15);
        chk("sat_b_saturated", b_out_saturated, 1);
        chk("sat_b_incremented", b_out_incremented, 0);
        chk("sat_a_counter", a_out_counter, 17);
        host_read(2, 0, va, vb);
        chk("sat_read_b", vb, 15);
        chk("sat_read_a", va, 17);

        // pd all-ones always increments
        for (int i = 0; i < 100; i++) upd(20, 0, 32'hFFFF_FFFF);
        idle();
        host_read(20, 0, va, vb);
        chk("pd_ones_a", va, 100);
        chk("pd_ones_b", vb, 15);

        // pd zero: rnd is a nonzero LFSR state, so never increments
        for (int i = 0; i < 100; i++) upd(21, 0, 32'h0);
        idle();
        host_read(21, 0, va, vb);
        chk("pd_zero_a", va, 0);

        // pd half-range
        for (int i = 0; i < 10000; i++) upd(22, 0, 32'h8000_0000);
        idle();
        mexp = cnt_a[22];
        host_read(22, 0, va, vb);
        chk("pd_half_model", va, mexp);
        chk("pd_half_range", (va > 4500 && va < 5500), 1);

        // Host collision with a stalled update to id 3
        for (int i = 0; i < 6; i++) upd(3, 1, 0);
        idle();
        in_valid = 1'b1; in_id = 8'd3; in_mode = 1'b1;
        host_req = 1'b1; host_id = 8'd3; host_clear = 1'b1;
        #1;
        chk("coll_in_ready", a_in_ready, 0);
        tick();
        host_req = 1'b0; host_clear = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("coll_host_valid", a_host_valid, 1);
        chk("coll_host_data", a_host_data, 6);
        tick();
        chk("coll_out_valid", a_out_valid, 1);
        chk("coll_out_counter", a_out_counter, 1);

        // Reset during an in-flight update to id 1
        upd(1, 1, 0); upd(1, 1, 0); idle(); idle();
        upd(1, 1, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("rstmid_out_valid", a_out_valid, 0);
        tick();
        rst = 1'b1;
        upd(10, 0, SEED - 32'd1);
        idle();
        chk("seed_minus1_inc", a_out_incremented, 0);
        host_read(1, 0, va, vb);
        chk("rstmid_mem1", va, 0);
        host_read(10, 0, va, vb);
        chk("seed_minus1_cnt", va, 0);

        // Second reset: first op compares against the seed itself
        rst = 1'b0;
        tick();
        rst = 1'b1;
        upd(11, 0, SEED);
        idle();
        chk("seed_eq_inc", a_out_incremented, 1);
        host_read(11, 0, va, vb);
        chk("seed_eq_cnt", va, 1);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
